// File: rtl/sec_locator_seq.sv
// Sequential single-error locator for shortened cyclic Hamming codes over GF(2^M).
// Optional SEC_LOC_EARLY_EXIT_EN ends the search on the first match instead of running the full length.
module sec_locator_seq #(
  parameter int             M     = 5,
  parameter logic [M-1:0]   POLY  = 5'b00101,
  parameter int             N_LEN = 29,
  parameter int             P     = 4,
  parameter int             LOC_W = $clog2(N_LEN+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [M-1:0]     s_syndrome,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_found,
  output logic             m_zero,
  output logic [LOC_W-1:0] m_loc
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam int         IDX_W  = LOC_W + 1;

  function automatic logic [M-1:0] mul_a(input logic [M-1:0] x);
    return {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY : '0);
  endfunction

  // Column i holds alpha^k * x^i; evaluated only for constant k at elaboration.
  function automatic logic [M-1:0][M-1:0] pow_mat(input int k);
    logic [M-1:0][M-1:0] mt;
    logic [M-1:0]        v;
    for (int i = 0; i < M; i++) begin
      v    = '0;
      v[i] = 1'b1;
      for (int j = 0; j < k; j++) v = mul_a(v);
      mt[i] = v;
    end
    return mt;
  endfunction

  function automatic logic [M-1:0] mat_mul(input logic [M-1:0][M-1:0] mt, input logic [M-1:0] x);
    logic [M-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) if (x[i]) r = r ^ mt[i];
    return r;
  endfunction

  localparam logic [M-1:0][M-1:0] MAT_P = pow_mat(P);

  logic [1:0]       state_q, state_d;
  logic [M-1:0]     syn_q, syn_d;
  logic [M-1:0]     cur_q, cur_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             found_q, found_d;
  logic             zero_q, zero_d;
  logic [LOC_W-1:0] loc_q, loc_d;
  logic [P-1:0]     lane_hit;
  logic [LOC_W-1:0] hit_loc;
  logic             hit_any;
  logic             last;

  // Lanes past the shortened length are masked even though their powers are valid field elements.
  for (genvar k = 0; k < P; k++) begin : g_lane
    localparam logic [M-1:0][M-1:0] MAT_K = pow_mat(k);
    assign lane_hit[k] = (mat_mul(MAT_K, cur_q) == syn_q) &&
                         ((idx_q + IDX_W'(k)) < IDX_W'(N_LEN));
  end

  assign hit_any = |lane_hit;
  assign last    = (idx_q + IDX_W'(P)) >= IDX_W'(N_LEN);

  always_comb begin
    hit_loc = '0;
    for (int k = 0; k < P; k++)
      if (lane_hit[k]) hit_loc = LOC_W'(idx_q + IDX_W'(k));
  end

  always_comb begin
    state_d = state_q;
    syn_d   = syn_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    found_d = found_q;
    zero_d  = zero_q;
    loc_d   = loc_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          syn_d   = s_syndrome;
          cur_d   = M'(1);
          idx_d   = '0;
          found_d = 1'b0;
          zero_d  = (s_syndrome == '0);
          loc_d   = (s_syndrome == '0) ? '0 : '1;
          state_d = (s_syndrome == '0) ? DONE : SEARCH;
        end
      end
      SEARCH: begin
        idx_d = idx_q + IDX_W'(P);
        cur_d = mat_mul(MAT_P, cur_q);
        if (hit_any && !found_q) begin
          found_d = 1'b1;
          loc_d   = hit_loc;
        end
`ifdef SEC_LOC_EARLY_EXIT_EN
        if (last || hit_any) state_d = DONE;
`else
        if (last) state_d = DONE;
`endif
      end
      DONE: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      syn_q   <= '0;
      cur_q   <= '0;
      idx_q   <= '0;
      found_q <= 1'b0;
      zero_q  <= 1'b0;
      loc_q   <= '0;
    end else begin
      state_q <= state_d;
      syn_q   <= syn_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      found_q <= found_d;
      zero_q  <= zero_d;
      loc_q   <= loc_d;
    end
  end

  assign s_ready = (state_q == IDLE);
  assign m_valid = (state_q == DONE);
  assign m_found = found_q;
  assign m_zero  = zero_q;
  assign m_loc   = loc_q;

endmodule

// File: tb/tb_sec_locator_seq.sv
// Bench for sec_locator_seq: directed vector table, backpressure/reset sequences and random syndromes vs a power-table model.
module tb_sec_locator_seq;
  localparam int M = 5, N_LEN = 29, P = 4, LOC_W = 5;
  localparam int FULL = (N_LEN + P - 1) / P;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [M-1:0]     s_syndrome = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             m_found;
  logic             m_zero;
  logic [LOC_W-1:0] m_loc;

  int checks = 0;
  int failures = 0;

  sec_locator_seq dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_syndrome(s_syndrome),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_found(m_found), .m_zero(m_zero), .m_loc(m_loc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: walk alpha^j through the field with plain shift/xor arithmetic.
  task automatic ref_model(input logic [M-1:0] syn, output bit f, output bit z,
                           output int loc, output int lat);
    int p;
    z = (syn == 0);
    f = 1'b0;
    loc = z ? 0 : (1 << LOC_W) - 1;
    lat = z ? 0 : FULL;
    p = 1;
    for (int j = 0; j < (1 << M) - 1; j++) begin
      if (!z && p == int'(syn) && j < N_LEN) begin
        f = 1'b1;
        loc = j;
`ifdef SEC_LOC_EARLY_EXIT_EN
        lat = j / P + 1;
`endif
      end
      p = p << 1;
      if (p >= (1 << M)) p = p ^ ((1 << M) | 5'b00101);
    end
  endtask

  task automatic do_txn(input string tag, input logic [M-1:0] syn, input int hold, input bit noise,
                        input bit ef, input bit ez, input int eloc, input int elat);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_syndrome = syn;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    if (noise) s_syndrome = M'($urandom);
    else s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, elat);
    chk({tag, "_found"}, m_found, ef);
    chk({tag, "_zero"}, m_zero, ez);
    chk({tag, "_loc"}, m_loc, eloc);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, m_valid, 1);
      chk({tag, "_hold_sready"}, s_ready, 0);
      chk({tag, "_hold_loc"}, m_loc, eloc);
      chk({tag, "_hold_found"}, m_found, ef);
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk({tag, "_rel_valid"}, m_valid, 0);
    chk({tag, "_rel_sready"}, s_ready, 1);
  endtask

  typedef struct {
    logic [M-1:0] syn;
    bit           f;
    bit           z;
    int           loc;
    int           lat_def;
    int           lat_early;
    int           hold;
  } vec_t;

  initial begin
    vec_t tbl[8];
    bit f, z;
    int loc, lat, elat;
    tbl[0] = '{5'h00, 1'b0, 1'b1, 0,  0, 0, 0};
    tbl[1] = '{5'h01, 1'b1, 1'b0, 0,  8, 1, 0};
    tbl[2] = '{5'h05, 1'b1, 1'b0, 5,  8, 2, 0};
    tbl[3] = '{5'h0D, 1'b1, 1'b0, 8,  8, 3, 0};
    tbl[4] = '{5'h12, 1'b0, 1'b0, 31, 8, 8, 0};
    tbl[5] = '{5'h09, 1'b0, 1'b0, 31, 8, 8, 0};
    tbl[6] = '{5'h05, 1'b1, 1'b0, 5,  8, 2, 5};
    tbl[7] = '{5'h02, 1'b1, 1'b0, 1,  8, 1, 0};

    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_sready", s_ready, 1);
    chk("rst_found", m_found, 0);
    chk("rst_zero", m_zero, 0);
    chk("rst_loc", m_loc, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
`ifdef SEC_LOC_EARLY_EXIT_EN
      elat = tbl[i].lat_early;
`else
      elat = tbl[i].lat_def;
`endif
      do_txn($sformatf("vec%0d", i), tbl[i].syn, tbl[i].hold, 1'b0,
             tbl[i].f, tbl[i].z, tbl[i].loc, elat);
    end

    // Reset during the third search cycle discards the pending search.
    @(negedge clk);
    s_valid = 1'b1;
    s_syndrome = 5'h05;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_sready", s_ready, 1);
    chk("midrst_found", m_found, 0);
    chk("midrst_loc", m_loc, 0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SEC_LOC_EARLY_EXIT_EN
    elat = 2;
`else
    elat = 8;
`endif
    do_txn("after_rst", 5'h05, 0, 1'b0, 1'b1, 1'b0, 5, elat);

    for (int i = 0; i < 40; i++) begin
      logic [M-1:0] rs;
      rs = M'($urandom);
      ref_model(rs, f, z, loc, lat);
      do_txn($sformatf("rnd%0d_s%0d", i, rs), rs, int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)), f, z, loc, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
